// File: rtl/sram_initiator_pkg.sv
// Shared types and width helpers for the SRAM request initiator.
package sram_initiator_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Minimum of 1 bit so degenerate sizes still produce legal vectors.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_initiator_rsp_fifo.sv
// Synchronous ring FIFO for read responses; head is visible combinationally, zero when empty.
// Push and pop may coincide at any occupancy; a push into a full FIFO is accepted only alongside a pop.
module rsp_fifo
    import sram_initiator_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int DATA_WIDTH = 4,
    localparam int PTR_W      = width_of(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_initiator.sv
// In-order read/write initiator for one sramRW port; read latency 2 (FALL_THROUGH=0) or 1, writes posted.
// reqReady derives from registered credit only, so buffered reads are never dropped; SRAM_CLEAR_ON_RESET_EN adds a zeroing sweep after reset.
module sram_initiator
    import sram_initiator_pkg::*;
#(
    parameter  int SIZE         = 16,
    parameter  int DATA_WIDTH   = 4,
    parameter  bit FALL_THROUGH = 1'b0,
    parameter  int RSP_DEPTH    = 4,
    localparam int ADDR_WIDTH   = width_of(SIZE)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [DATA_WIDTH-1:0] reqData,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [DATA_WIDTH-1:0] rspData,
    output logic                  memEn,
    output logic                  memR,
    output logic                  memW,
    output logic [ADDR_WIDTH-1:0] memRAddr,
    output logic [ADDR_WIDTH-1:0] memWAddr,
    output logic [DATA_WIDTH-1:0] memIn,
    input  logic [DATA_WIDTH-1:0] memOut,
    output logic                  initDone
);

    localparam int CNT_W = width_of(RSP_DEPTH) + 1;

    logic                  init_done;
    logic [CNT_W-1:0]      credit;
    logic                  pend;
    logic                  acc;
    logic                  rd_acc;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  unused_fifo;
    logic                  clr_w;
    logic [ADDR_WIDTH-1:0] clr_addr;

    assign initDone = init_done;
    assign reqReady = init_done && (credit < CNT_W'(RSP_DEPTH));
    assign acc      = reqValid && reqReady;
    assign rd_acc   = acc && !reqWrite;
    assign rspValid = !fifo_empty;
    assign pop      = rspValid && rspReady;
    // Registered SRAM output lands one cycle after the strobe; combinational output lands immediately.
    assign push     = FALL_THROUGH ? rd_acc : pend;

`ifdef SRAM_CLEAR_ON_RESET_EN
    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] sweep;
    logic [ADDR_WIDTH-1:0] sweep_nxt;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= CLEAR;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        clr_w     = 1'b0;
        if (state == CLEAR && rstN) begin
            clr_w     = 1'b1;
            sweep_nxt = sweep + 1'b1;
            if (sweep == ADDR_WIDTH'(SIZE - 1)) state_nxt = RUN;
        end
    end

    assign clr_addr  = sweep;
    assign init_done = (state == RUN);
`else
    always_ff @(posedge clk) begin
        if (!rstN) init_done <= 1'b0;
        else       init_done <= 1'b1;
    end

    assign clr_w    = 1'b0;
    assign clr_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rstN) begin
            credit <= '0;
            pend   <= 1'b0;
        end else begin
            pend <= rd_acc && !FALL_THROUGH;
            case ({rd_acc, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_comb begin
        memEn    = acc || clr_w;
        memW     = (acc && reqWrite) || clr_w;
        memR     = rd_acc;
        memRAddr = reqAddr;
        memWAddr = clr_w ? clr_addr : reqAddr;
        memIn    = clr_w ? '0 : reqData;
    end

    rsp_fifo #(
        .DEPTH      (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (push),
        .din   (memOut),
        .pop   (pop),
        .dout  (rspData),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Credit already bounds occupancy, so the FIFO's own status is informational.
    assign unused_fifo = &{1'b0, fifo_full, fifo_count};

endmodule
